// File: rtl/carry_select_subtractor_661010_pipelined.sv
// Pipelined 32-bit carry-select subtractor, D = A - B - Bin.
// Each of the four blocks (6/6/10/10) is resolved in its own pipeline stage.
// Subtraction is done as A + ~B + ~Bin. The carry out of each block is
// registered and selects between the two precomputed sums of the next block.
// A single global enable advances or freezes the whole pipe, which gives full
// backpressure. The downstream ready signal feeds back combinationally to in_ready.
`timescale 1ns/1ps
module carry_select_subtractor_661010_pipelined #(
  parameter int WIDTH = 32,
  parameter int BLK0  = 6,
  parameter int BLK1  = 6,
  parameter int BLK2  = 10,
  parameter int BLK3  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int O1 = BLK0;
  localparam int O2 = BLK0 + BLK1;
  localparam int O3 = BLK0 + BLK1 + BLK2;

  generate
    if ((BLK0 + BLK1 + BLK2 + BLK3) != WIDTH || BLK0 < 1 || BLK1 < 1 || BLK2 < 1 || BLK3 < 1) begin : g_bad_split
      $error("block widths must be >= 1 and sum to WIDTH");
    end
  endgenerate

  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  logic             vld_p0, vld_p1, vld_p2;
  logic             cy_p0, cy_p1, cy_p2;
  logic [O1-1:0]    d_p0;
  logic [O2-1:0]    d_p1;
  logic [O3-1:0]    d_p2;
  logic [WIDTH-1:O1] a_p0, b_p0;
  logic [WIDTH-1:O2] a_p1, b_p1;
  logic [WIDTH-1:O3] a_p2, b_p2;

  // ---- stage 0: block 0, single RCA with carry-in = ~Bin
  logic [BLK0:0] s0;
  assign s0 = {1'b0, A[O1-1:0]} + {1'b0, ~B[O1-1:0]} + {{BLK0{1'b0}}, ~Bin};

  // ---- stage 1: block 1, dual RCA selected by the stage-0 carry
  logic [BLK1:0] s1_z, s1_o, s1;
  assign s1_z = {1'b0, a_p0[O2-1:O1]} + {1'b0, ~b_p0[O2-1:O1]};
  assign s1_o = {1'b0, a_p0[O2-1:O1]} + {1'b0, ~b_p0[O2-1:O1]} + {{BLK1{1'b0}}, 1'b1};
  assign s1   = cy_p0 ? s1_o : s1_z;

  // ---- stage 2: block 2, dual RCA selected by the stage-1 carry
  logic [BLK2:0] s2_z, s2_o, s2;
  assign s2_z = {1'b0, a_p1[O3-1:O2]} + {1'b0, ~b_p1[O3-1:O2]};
  assign s2_o = {1'b0, a_p1[O3-1:O2]} + {1'b0, ~b_p1[O3-1:O2]} + {{BLK2{1'b0}}, 1'b1};
  assign s2   = cy_p1 ? s2_o : s2_z;

  // ---- stage 3: block 3, dual RCA selected by the stage-2 carry
  logic [BLK3:0] s3_z, s3_o, s3;
  assign s3_z = {1'b0, a_p2[WIDTH-1:O3]} + {1'b0, ~b_p2[WIDTH-1:O3]};
  assign s3_o = {1'b0, a_p2[WIDTH-1:O3]} + {1'b0, ~b_p2[WIDTH-1:O3]} + {{BLK3{1'b0}}, 1'b1};
  assign s3   = cy_p2 ? s3_o : s3_z;

  // Valid chain and output registers: cleared by reset, shift together on en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
      D         <= '0;
      Bout      <= 1'b0;
      V         <= 1'b0;
    end else if (en) begin
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      out_valid <= vld_p2;
      D         <= {s3[BLK3-1:0], d_p2};
      Bout      <= ~s3[BLK3];
      V         <= (a_p2[WIDTH-1] ^ b_p2[WIDTH-1]) & (s3[BLK3-1] ^ a_p2[WIDTH-1]);
    end
  end

  // Partial differences, block carries and skewed operand bits (no reset needed)
  always_ff @(posedge clk) begin
    if (en) begin
      d_p0  <= s0[BLK0-1:0];
      cy_p0 <= s0[BLK0];
      a_p0  <= A[WIDTH-1:O1];
      b_p0  <= B[WIDTH-1:O1];
      d_p1  <= {s1[BLK1-1:0], d_p0};
      cy_p1 <= s1[BLK1];
      a_p1  <= a_p0[WIDTH-1:O2];
      b_p1  <= b_p0[WIDTH-1:O2];
      d_p2  <= {s2[BLK2-1:0], d_p1};
      cy_p2 <= s2[BLK2];
      a_p2  <= a_p1[WIDTH-1:O3];
      b_p2  <= b_p1[WIDTH-1:O3];
    end
  end

endmodule

// File: tb/tb_carry_select_subtractor_661010_pipelined.sv
// Testbench for the pipelined carry-select subtractor.
`timescale 1ns/1ps
module tb_carry_select_subtractor_661010_pipelined;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] D;
  logic        Bout;
  logic        V;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];
  int          t_q[$];

  carry_select_subtractor_661010_pipelined dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .Bout(Bout), .V(V)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Reference: {V, Bout, D} for A - B - Bin
  function automatic logic [33:0] model(logic [31:0] a, logic [31:0] b, logic bin);
    logic [32:0] r;
    r = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    return {(a[31] != b[31]) && (r[31] != a[31]), r};
  endfunction

  // One clock: snapshot handshake state mid-cycle, record output transfers, advance
  task automatic tick(output bit acc, output bit ovld, output bit irdy, output logic [31:0] dq);
    #1;
    acc  = in_valid && in_ready;
    ovld = out_valid;
    irdy = in_ready;
    dq   = D;
    if (out_valid && out_ready) begin
      got_q.push_back({V, Bout, D});
      t_q.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    t_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (D !== 32'h0) begin bad++; $display("FAIL rst_D: got %h want 00000000", D); end
    total++; if (Bout !== 1'b0) begin bad++; $display("FAIL rst_Bout: got %b want 0", Bout); end
    total++; if (V !== 1'b0) begin bad++; $display("FAIL rst_V: got %b want 0", V); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_directed(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic bin, input logic [31:0] ed, input logic eb, input logic ev);
    bit acc, ovld, irdy;
    logic [31:0] dq;
    int n;
    A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = 1'b1;
    tick(acc, ovld, irdy, dq);
    in_valid = 1'b0;
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL %s_accept: got %b want 1", name, acc); end
    n = 1;
    #1;
    while (!out_valid && n < 20) begin
      @(posedge clk); @(negedge clk); #1;
      n++;
    end
    total++; if (n != 4) begin bad++; $display("FAIL %s_latency: got %0d want 4", name, n); end
    total++; if (D !== ed) begin bad++; $display("FAIL %s_D: got %h want %h", name, D, ed); end
    total++; if (Bout !== eb) begin bad++; $display("FAIL %s_Bout: got %b want %b", name, Bout, eb); end
    total++; if (V !== ev) begin bad++; $display("FAIL %s_V: got %b want %b", name, V, ev); end
    @(posedge clk); @(negedge clk);
  endtask

  // Hand-computed vectors shared by the streaming tests
  logic [31:0] ta [8] = '{32'h0000_000A, 32'h0000_0040, 32'h0010_0000, 32'hFFFF_FFFF,
                          32'h1234_5678, 32'h0000_0000, 32'h7FFF_FFFF, 32'hDEAD_BEEF};
  logic [31:0] tb [8] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF,
                          32'h1111_1111, 32'h8000_0000, 32'h0000_0000, 32'h0000_BEEF};
  logic        tbin [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [33:0] texp [8] = '{{2'b00, 32'h0000_0007}, {2'b00, 32'h0000_003F},
                            {2'b00, 32'h000F_FFFF}, {2'b01, 32'hFFFF_FFFF},
                            {2'b00, 32'h0123_4567}, {2'b11, 32'h8000_0000},
                            {2'b00, 32'h7FFF_FFFE}, {2'b00, 32'hDEAD_0000}};

  task automatic test_back_to_back();
    bit acc, ovld, irdy;
    logic [31:0] dq;
    int i, g;
    clear_queues();
    out_ready = 1'b1;
    i = 0; g = 0;
    while (i < 8 && g < 40) begin
      A = ta[i]; B = tb[i]; Bin = tbin[i]; in_valid = 1'b1;
      tick(acc, ovld, irdy, dq);
      if (acc) i++;
      g++;
    end
    in_valid = 1'b0;
    g = 0;
    while (got_q.size() < 8 && g < 20) begin
      tick(acc, ovld, irdy, dq);
      g++;
    end
    total++; if (got_q.size() != 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", got_q.size()); end
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      total++; if (got_q[k] !== texp[k]) begin bad++; $display("FAIL b2b_item%0d: got %h want %h", k, got_q[k], texp[k]); end
      total++; if (t_q[k] != t_q[0] + k) begin bad++; $display("FAIL b2b_cycle%0d: got %0d want %0d", k, t_q[k], t_q[0] + k); end
    end
  endtask

  task automatic test_stall();
    bit acc, ovld, irdy, stalled, prev_stall;
    logic [31:0] dq, prev_d;
    int i, c, stalls;
    clear_queues();
    i = 0; c = 0; stalls = 0; prev_stall = 1'b0; prev_d = '0;
    while (got_q.size() < 6 && c < 60) begin
      out_ready = (c >= 5 && c <= 9) ? 1'b0 : 1'b1;
      if (i < 6) begin
        A = ta[i]; B = tb[i]; Bin = tbin[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick(acc, ovld, irdy, dq);
      if (acc) i++;
      stalled = ovld && !out_ready;
      if (stalled) begin
        stalls++;
        total++; if (irdy !== 1'b0) begin bad++; $display("FAIL stall_in_ready_c%0d: got %b want 0", c, irdy); end
      end
      if (prev_stall) begin
        total++; if (dq !== prev_d) begin bad++; $display("FAIL stall_D_stable_c%0d: got %h want %h", c, dq, prev_d); end
      end
      prev_stall = stalled;
      prev_d = dq;
      c++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++; if (stalls != 5) begin bad++; $display("FAIL stall_cycles: got %0d want 5", stalls); end
    total++; if (got_q.size() != 6) begin bad++; $display("FAIL stall_count: got %0d want 6", got_q.size()); end
    for (int k = 0; k < 6 && k < got_q.size(); k++) begin
      total++; if (got_q[k] !== texp[k]) begin bad++; $display("FAIL stall_item%0d: got %h want %h", k, got_q[k], texp[k]); end
    end
  endtask

  task automatic test_reset_midstream();
    bit acc, ovld, irdy;
    logic [31:0] dq;
    clear_queues();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      A = ta[k + 3]; B = tb[k + 3]; Bin = tbin[k + 3]; in_valid = 1'b1;
      tick(acc, ovld, irdy, dq);
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
    total++; if (D !== 32'h0) begin bad++; $display("FAIL mid_rst_D: got %h want 00000000", D); end
    total++; if (Bout !== 1'b0) begin bad++; $display("FAIL mid_rst_Bout: got %b want 0", Bout); end
    total++; if (V !== 1'b0) begin bad++; $display("FAIL mid_rst_V: got %b want 0", V); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) tick(acc, ovld, irdy, dq);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL mid_rst_stale: got %0d results want 0", got_q.size()); end
  endtask

  task automatic test_random();
    bit acc, ovld, irdy;
    logic [31:0] dq;
    int issued, g;
    clear_queues();
    issued = 0; g = 0;
    while (issued < 10000 && g < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      A   = $urandom;
      B   = $urandom;
      Bin = $urandom_range(0, 1);
      tick(acc, ovld, irdy, dq);
      if (acc) begin
        exp_q.push_back(model(A, B, Bin));
        issued++;
      end
      g++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    g = 0;
    while (got_q.size() < exp_q.size() && g < 50) begin
      tick(acc, ovld, irdy, dq);
      g++;
    end
    total++; if (issued != 10000) begin bad++; $display("FAIL rand_issued: got %0d want 10000", issued); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL rand_item%0d: got %h want %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_directed("basic",    32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    test_directed("wrap",     32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    test_directed("ovf",      32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    test_directed("bin_full", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
